// File: rtl/audio_pkg.sv
// Shared constants and helpers for the tone/sequencer blocks.
//   - Default divider and step-timing constants.
//   - Note half-periods B1..A3 in synth ticks, for the default SYNTH_DIV
//     and a 12 MHz clk.
//   - clog2 / cnt_w: width helpers for the counters.
package audio_pkg;

  localparam int unsigned DEF_SYNTH_DIV      = 1024;
  localparam int unsigned DEF_TICK_DIV       = 131072;
  localparam int unsigned DEF_TICKS_PER_STEP = 20;
  localparam int unsigned DEF_GATE_TICKS     = 10;

  localparam logic [6:0] NOTE_REST = 7'd0;
  localparam logic [6:0] NOTE_B1   = 7'd95;
  localparam logic [6:0] NOTE_C2   = 7'd90;
  localparam logic [6:0] NOTE_D2   = 7'd80;
  localparam logic [6:0] NOTE_E2   = 7'd71;
  localparam logic [6:0] NOTE_F2   = 7'd67;
  localparam logic [6:0] NOTE_G2   = 7'd60;
  localparam logic [6:0] NOTE_A2   = 7'd53;
  localparam logic [6:0] NOTE_B2   = 7'd47;
  localparam logic [6:0] NOTE_C3   = 7'd45;
  localparam logic [6:0] NOTE_D3   = 7'd40;
  localparam logic [6:0] NOTE_E3   = 7'd36;
  localparam logic [6:0] NOTE_F3   = 7'd34;
  localparam logic [6:0] NOTE_G3   = 7'd30;
  localparam logic [6:0] NOTE_A3   = 7'd27;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v < 2) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave tone oscillator for one voice.
//   clk, rst_n  : clock, async active-low reset
//   synth_tick  : clock enable for the half-period counter
//   load        : step boundary; restarts the phase (cnt=0, sq=0)
//   gate        : voice sounding; while low the oscillator is held cleared
//   hp          : half-period in synth ticks (non-zero while gated)
//   sq          : square-wave output
module tone_osc
  import audio_pkg::*;
#(
  parameter int unsigned PERIOD_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                synth_tick,
  input  logic                load,
  input  logic                gate,
  input  logic [PERIOD_W-1:0] hp,
  output logic                sq
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                sq_q, sq_d;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (load || !gate) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (synth_tick) begin
      if (cnt_q == '0) begin
        sq_d  = ~sq_q;
        cnt_d = hp - PERIOD_W'(1);
      end else begin
        cnt_d = cnt_q - PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/poly_seq_engine.sv
// Multi-voice pattern sequencer with square-wave voices and a 1-bit
// sigma-delta mixer.
//   clk, rst_n : clock, async active-low reset
//   run        : 1 = advance and sound, 0 = paused and silent
//   loop_len   : index of the last step of the loop
//   step       : current step index (pattern ROM address)
//   note_hp    : per-voice half-periods for `step`, 0 = rest
//   step_stb   : one-cycle pulse when `step` shows a new value
//   gate       : per-voice sounding flags
//   audio      : sigma-delta output, duty = active voices / NUM_CH
module poly_seq_engine
  import audio_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned PERIOD_W       = 7,
  parameter int unsigned STEP_W         = 7,
  parameter int unsigned SYNTH_DIV      = DEF_SYNTH_DIV,
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int unsigned GATE_TICKS     = DEF_GATE_TICKS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [STEP_W-1:0]            loop_len,
  output logic [STEP_W-1:0]            step,
  input  logic [NUM_CH*PERIOD_W-1:0]   note_hp,
  output logic                         step_stb,
  output logic [NUM_CH-1:0]            gate,
  output logic                         audio
);

  localparam int unsigned SDW = cnt_w(SYNTH_DIV);
  localparam int unsigned TDW = cnt_w(TICK_DIV);
  localparam int unsigned KW  = cnt_w(TICKS_PER_STEP);
  localparam int unsigned AW  = cnt_w(2 * NUM_CH);

  logic [SDW-1:0]                   syn_cnt_q, syn_cnt_d;
  logic [TDW-1:0]                   seq_cnt_q, seq_cnt_d;
  logic [KW-1:0]                    tick_q, tick_d;
  logic [STEP_W-1:0]                step_q, step_d;
  logic                             stb_q, stb_d;
  logic                             pend_q, pend_d;
  logic [NUM_CH-1:0][PERIOD_W-1:0]  hp_lat_q, hp_lat_d;
  logic [NUM_CH-1:0]                gate_q, gate_d;
  logic [AW-1:0]                    acc_q, acc_d;
  logic                             audio_q, audio_d;
  logic [NUM_CH-1:0]                sq;
  logic [AW-1:0]                    sum, mix_t;
  logic                             adv, synth_tick, seq_tick, wrap;

  always_comb begin
    // The initial step-0 load occupies its own cycle; counting starts after
    // it so the first step lasts a full step period like every other one.
    adv        = run & ~pend_q;
    synth_tick = adv & (32'(syn_cnt_q) == SYNTH_DIV - 1);
    seq_tick   = adv & (32'(seq_cnt_q) == TICK_DIV - 1);
    wrap       = seq_tick & (32'(tick_q) == TICKS_PER_STEP - 1);

    syn_cnt_d = syn_cnt_q;
    if (adv) syn_cnt_d = synth_tick ? '0 : syn_cnt_q + SDW'(1);
    seq_cnt_d = seq_cnt_q;
    if (adv) seq_cnt_d = seq_tick ? '0 : seq_cnt_q + TDW'(1);
    tick_d = tick_q;
    if (seq_tick) tick_d = wrap ? '0 : tick_q + KW'(1);
    step_d = step_q;
    if (wrap) step_d = (step_q >= loop_len) ? '0 : step_q + STEP_W'(1);

    stb_d    = (run & pend_q) | wrap;
    pend_d   = pend_q & ~run;
    hp_lat_d = stb_q ? note_hp : hp_lat_q;

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      gate_d[k] = run & (32'(tick_q) < GATE_TICKS) & (hp_lat_q[k] != '0);
    end

    sum = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sum = sum + AW'(gate_q[k] & sq[k]);
    end
    mix_t = acc_q + sum;
    if (32'(mix_t) >= NUM_CH) begin
      audio_d = 1'b1;
      acc_d   = mix_t - AW'(NUM_CH);
    end else begin
      audio_d = 1'b0;
      acc_d   = mix_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_cnt_q <= '0;
      seq_cnt_q <= '0;
      tick_q    <= '0;
      step_q    <= '0;
      stb_q     <= 1'b0;
      pend_q    <= 1'b1;
      hp_lat_q  <= '0;
      gate_q    <= '0;
      acc_q     <= '0;
      audio_q   <= 1'b0;
    end else begin
      syn_cnt_q <= syn_cnt_d;
      seq_cnt_q <= seq_cnt_d;
      tick_q    <= tick_d;
      step_q    <= step_d;
      stb_q     <= stb_d;
      pend_q    <= pend_d;
      hp_lat_q  <= hp_lat_d;
      gate_q    <= gate_d;
      acc_q     <= acc_d;
      audio_q   <= audio_d;
    end
  end

  // Oscillators see the next-state gate so sq and gate change on the same edge.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_voice
    tone_osc #(.PERIOD_W(PERIOD_W)) u_osc (
      .clk        (clk),
      .rst_n      (rst_n),
      .synth_tick (synth_tick),
      .load       (stb_q),
      .gate       (gate_d[k]),
      .hp         (hp_lat_q[k]),
      .sq         (sq[k])
    );
  end

  assign step     = step_q;
  assign step_stb = stb_q;
  assign gate     = gate_q;
  assign audio    = audio_q;

endmodule

// File: tb/tb_poly_seq_engine.sv
module tb_poly_seq_engine;

  localparam int unsigned NCH = 2;
  localparam int unsigned PW  = 7;
  localparam int unsigned SW  = 7;
  localparam int unsigned SD  = 2;
  localparam int unsigned TD  = 4;
  localparam int unsigned TPS = 4;
  localparam int unsigned GT  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                run = 1'b0;
  logic [SW-1:0]       loop_len = '0;
  logic [NCH*PW-1:0]   note_hp = '0;
  logic [SW-1:0]       step;
  logic                step_stb;
  logic [NCH-1:0]      gate;
  logic                audio;
  logic [NCH-1:0]      dut_sq;

  poly_seq_engine #(
    .NUM_CH(NCH), .PERIOD_W(PW), .STEP_W(SW), .SYNTH_DIV(SD),
    .TICK_DIV(TD), .TICKS_PER_STEP(TPS), .GATE_TICKS(GT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .loop_len(loop_len), .step(step),
    .note_hp(note_hp), .step_stb(step_stb), .gate(gate), .audio(audio)
  );

  assign dut_sq = {dut.g_voice[1].u_osc.sq, dut.g_voice[0].u_osc.sq};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position in the pattern is derived from the number
  // of advancing cycles; each oscillator from the synth ticks seen since it
  // was last silenced; the mixer as a running remainder modulo NUM_CH.
  int m_adv, m_step, m_acc;
  bit m_pend, m_stb, m_audio;
  int m_hp[NCH];
  int m_n[NCH];
  bit m_gate[NCH];
  bit m_sq[NCH];

  initial forever begin
    bit adv, stick, bnd, stb_new;
    int tk, sum;
    bit g_new[NCH];
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_adv = 0; m_step = 0; m_acc = 0; m_pend = 1; m_stb = 0; m_audio = 0;
      for (int k = 0; k < NCH; k++) begin
        m_hp[k] = 0; m_n[k] = 0; m_gate[k] = 0; m_sq[k] = 0;
      end
    end else begin
      adv   = run && !m_pend;
      tk    = (m_adv / TD) % TPS;
      stick = adv && ((m_adv % SD) == SD - 1);
      bnd   = adv && (((m_adv + 1) % (TD * TPS)) == 0);
      sum = 0;
      for (int k = 0; k < NCH; k++) sum += (m_gate[k] && m_sq[k]) ? 1 : 0;
      for (int k = 0; k < NCH; k++) g_new[k] = run && (tk < GT) && (m_hp[k] != 0);
      for (int k = 0; k < NCH; k++) begin
        if (m_stb || !g_new[k]) begin
          m_n[k] = 0; m_sq[k] = 0;
        end else if (stick) begin
          m_n[k]++;
          m_sq[k] = (((m_n[k] - 1) / m_hp[k]) % 2) == 0;
        end
        m_gate[k] = g_new[k];
      end
      if (m_stb) for (int k = 0; k < NCH; k++) m_hp[k] = int'(note_hp[k*PW +: PW]);
      m_audio = (m_acc + sum) >= NCH;
      m_acc   = (m_acc + sum) % NCH;
      if (bnd) m_step = (m_step >= int'(loop_len)) ? 0 : m_step + 1;
      stb_new = (run && m_pend) || bnd;
      m_pend  = m_pend && !run;
      if (adv) m_adv++;
      m_stb = stb_new;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    logic [NCH-1:0] eg, es;
    @(negedge clk);
    for (int k = 0; k < NCH; k++) begin
      eg[k] = m_gate[k];
      es[k] = m_sq[k];
    end
    check("model.step", int'(step), m_step);
    check("model.step_stb", int'(step_stb), int'(m_stb));
    check("model.gate", int'(gate), int'(eg));
    check("model.sq", int'(dut_sq), int'(es));
    check("model.audio", int'(audio), int'(m_audio));
  end

  task automatic do_reset(input logic r, input logic [NCH*PW-1:0] hp,
                          input logic [SW-1:0] ll);
    @(negedge clk);
    rst_n = 1'b0;
    run = r; note_hp = hp; loop_len = ll;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic adv_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int a_gate[12]  = '{0,0,1,1,1,1,1,1,1,0,0,0};
  int a_sq[12]    = '{0,0,1,1,1,1,1,1,0,0,0,0};
  int a_audio[12] = '{0,0,0,0,1,0,1,0,1,0,0,0};
  int b_sq[12]    = '{0,0,3,3,0,0,3,3,0,0,0,0};
  int b_audio[12] = '{0,0,0,1,1,0,0,1,1,0,0,0};
  int a_steps[6]  = '{0,1,2,0,1,2};

  initial begin
    int g0, g1, n;

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset.step", int'(step), 0);
    check("reset.stb", int'(step_stb), 0);
    check("reset.gate", int'(gate), 0);
    check("reset.audio", int'(audio), 0);

    // Voice0 hp=3, voice1 rest, loop 0..2.
    do_reset(1'b1, {7'd0, 7'd3}, 7'd2);
    for (int c = 1; c <= 12; c++) begin
      adv_to(c);
      check($sformatf("A.stb c%0d", c), int'(step_stb), (c == 1) ? 1 : 0);
      check($sformatf("A.gate c%0d", c), int'(gate), a_gate[c-1]);
      check($sformatf("A.sq0 c%0d", c), int'(dut_sq[0]), a_sq[c-1]);
      check($sformatf("A.audio c%0d", c), int'(audio), a_audio[c-1]);
    end
    check("A.step c1", int'(step), 0);
    g0 = 0; g1 = 0;
    for (int i = 1; i < 6; i++) begin
      while (cyc < 1 + 16 * i) begin
        adv_to(cyc + 1);
        if (i == 2) begin
          g0 += int'(gate[0]);
          g1 += int'(gate[1]);
        end
      end
      check($sformatf("A.stb step%0d", i), int'(step_stb), 1);
      check($sformatf("A.step seq%0d", i), int'(step), a_steps[i]);
    end
    check("A.gate0 on-cycles per step", g0, 8);
    check("A.gate1 on-cycles", g1, 0);
    adv_to(90);
    loop_len = 7'd0;
    adv_to(97);
    check("A.shrink stb", int'(step_stb), 1);
    check("A.shrink step", int'(step), 0);
    adv_to(113);
    check("A.shrink2 step", int'(step), 0);

    // Both voices hp=1 in phase, then async reset mid-step.
    do_reset(1'b1, {7'd1, 7'd1}, 7'd3);
    for (int c = 1; c <= 12; c++) begin
      adv_to(c);
      check($sformatf("B.sq c%0d", c), int'(dut_sq), b_sq[c-1]);
      check($sformatf("B.audio c%0d", c), int'(audio), b_audio[c-1]);
    end
    adv_to(20);
    check("B.pre-rst step", int'(step), 1);
    check("B.pre-rst gate", int'(gate), 3);
    check("B.pre-rst audio", int'(audio), 1);
    #2 rst_n = 1'b0;
    #1;
    check("B.async step", int'(step), 0);
    check("B.async stb", int'(step_stb), 0);
    check("B.async gate", int'(gate), 0);
    check("B.async sq", int'(dut_sq), 0);
    check("B.async audio", int'(audio), 0);

    // run dropped mid-gate.
    do_reset(1'b1, {7'd0, 7'd3}, 7'd5);
    adv_to(20);
    check("D.gate before pause", int'(gate), 1);
    run = 1'b0;
    adv_to(21);
    check("D.gate after pause", int'(gate), 0);
    check("D.sq after pause", int'(dut_sq), 0);
    n = 0;
    while (cyc < 60) begin
      adv_to(cyc + 1);
      if (step != 7'd1 || step_stb || gate != '0) n++;
    end
    check("D.frozen violations", n, 0);
    check("D.audio settled", int'(audio), 0);
    run = 1'b1;
    n = 0;
    while (cyc < 72) begin
      adv_to(cyc + 1);
      n += int'(step_stb);
    end
    check("D.stb during resume", n, 0);
    check("D.step before resume boundary", int'(step), 1);
    adv_to(73);
    check("D.resume stb", int'(step_stb), 1);
    check("D.resume step", int'(step), 2);

    // Release with run=0: initial load deferred.
    do_reset(1'b0, {7'd0, 7'd2}, 7'd1);
    adv_to(5);
    check("E.idle stb", int'(step_stb), 0);
    check("E.idle gate", int'(gate), 0);
    run = 1'b1;
    adv_to(6);
    check("E.deferred stb", int'(step_stb), 1);
    check("E.deferred step", int'(step), 0);
    adv_to(22);
    check("E.next stb", int'(step_stb), 1);
    check("E.next step", int'(step), 1);
    adv_to(38);
    check("E.wrap stb", int'(step_stb), 1);
    check("E.wrap step", int'(step), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_seq_engine.md
# poly_seq_engine

Parametrised multi-channel successor to the single-voice sequencer/synth pair. It steps through an externally supplied pattern ROM, drives NUM_CH square-wave tone oscillators with per-step gating and rests, and mixes them into the 1-bit `audio` pin through a first-order sigma-delta modulator. All timing comes from clock-enable ticks inside the `clk` domain; the block generates no derived clocks.

## Interface
- NUM_CH, 2: number of voices, 1..8.
- PERIOD_W, 7: half-period width, in synth ticks.
- STEP_W, 7: step index width.
- SYNTH_DIV, 1024: clk cycles per synth tick.
- TICK_DIV, 131072: clk cycles per sequencer tick.
- TICKS_PER_STEP, 20: sequencer ticks per step.
- GATE_TICKS, 10: ticks per step during which a voice sounds. Must satisfy GATE_TICKS ≤ TICKS_PER_STEP.
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- run  in  1  1 = sequencer advances. 0 = paused and silent.
- loop_len  in  STEP_W  index of the last step in the loop.
- step  out  STEP_W  current step index, addressing the external pattern ROM.
- note_hp  in  NUM_CH*PERIOD_W  half-periods for `step`. Voice k occupies bits [k*PERIOD_W +: PERIOD_W]. 0 = rest.
- step_stb  out  1  one-cycle pulse: `step` holds a new value.
- gate  out  NUM_CH  per-voice sounding flag.
- audio  out  1  sigma-delta output.

## Operation
- Prescalers:
  - synth_tick pulses once every SYNTH_DIV cycles.
  - seq_tick pulses once every TICK_DIV cycles.
  - Both counters free-run while run=1 and hold while run=0.
- Sequencer:
  - tick_ctr counts 0..TICKS_PER_STEP-1 on seq_tick.
  - When tick_ctr wraps: if step ≥ loop_len, step becomes 0; otherwise step becomes step+1.
  - step_stb is high in the first cycle that shows the new step.
- Note latch:
  - On the clk edge that ends a step_stb=1 cycle, hp_lat[k] <= note_hp[k].
  - The ROM therefore has one full cycle of combinational settle time.
- Gate: gate[k] = run & (tick_ctr < GATE_TICKS) & (hp_lat[k] != 0). The output is registered.
- Oscillator (per voice):
  - While gate[k]=0: cnt=0 and sq=0.
  - On a synth_tick with gate[k]=1: if cnt==0, sq toggles and cnt <= hp_lat[k]-1; otherwise cnt decrements.
  - Phase restarts at every step boundary because the load of hp_lat forces cnt=0 and sq=0.
- Mixer:
  - sum = Σ (gate[k] & sq[k]), range 0..NUM_CH.
  - Accumulator acc holds values 0..NUM_CH-1.
  - Every clk: t = acc + sum. If t ≥ NUM_CH then audio <= 1 and acc <= t-NUM_CH; otherwise audio <= 0 and acc <= t.
  - Resulting duty cycle is sum/NUM_CH. With NUM_CH=1, audio equals the registered sq.

## Timing
- Reset (async assert) values: step=0, tick_ctr=0, prescalers=0, hp_lat=0, gate=0, sq=0, acc=0, audio=0, step_stb=0.
- First cycle after rst_n deasserts with run=1: step_stb=1 with step=0, so step 0 is latched.
- If run=0 at release, this load is deferred to the first cycle in which run=1.
- Step latency: step_stb → hp_lat valid is 1 cycle. hp_lat → gate/sq is 1 cycle. sq → audio is 1 cycle.
- Step period = TICK_DIV*TICKS_PER_STEP cycles. Gate-on time = GATE_TICKS*TICK_DIV cycles.
- Changing loop_len while step > loop_len: the next advance wraps to 0; step is never forced mid-step.
- run falling:
  - gate drops on the next edge.
  - Counters, step and hp_lat hold.
  - Oscillators clear.
  - acc and audio continue processing sum=0, so audio settles to 0.
- run rising: resumes from the held counters. No step_stb unless the initial load is still pending.
- seq_tick and synth_tick in the same cycle: both act; the step-boundary reload takes priority over the oscillator update.
- rst_n asserted mid-step: all state clears immediately, without waiting for a clk edge.

## Structure
- Package `audio_pkg`:
  - note half-period constants (B1..A3 at the default SYNTH_DIV),
  - a clog2 function,
  - default divider constants.
- Sub-module `tone_osc`: one per voice, instantiated in a generate loop. Ports: clk, rst_n, synth_tick, load, gate, hp, sq.
- The top level owns the prescalers, sequencer, note latch and mixer.

## Test plan
All directed tests use NUM_CH=2, SYNTH_DIV=2, TICK_DIV=4, TICKS_PER_STEP=4, GATE_TICKS=2.
- Reset release with run=1:
  - step_stb high in cycle 1 with step=0.
  - Next step_stb 16 cycles later with step=1.
- loop_len=2 over 64 cycles:
  - step sequence 0,1,2,0.
  - Then drop loop_len to 0 while step=2: next advance gives step=0.
- note_hp={0,3}:
  - voice0 sq toggles every 6 cycles while gated.
  - gate[1]=0 throughout.
  - gate[0] high for 8 of every 16 cycles.
- Both voices hp=1 and in phase: audio equals sq exactly.
  - With voice1 at rest, audio alternates 1,0 while voice0 sq=1.
- run dropped mid-gate: gate=0 next cycle and step frozen for 40 cycles. On run=1, step advances after the remaining ticks, with no extra step_stb.
- rst_n pulsed asynchronously between clk edges: all outputs read 0 before the next clk edge.
